// File: rtl/stack_sequencer_if.sv
// Request/control bundle between the EX-stage stack path and stack_sequencer.
// The sequencer side uses the master modport; the stage/decode side uses slave.
interface stack_sequencer_if;
    logic        i_call;
    logic        i_ret;
    logic        i_rti;
    logic        i_int;
    logic        o_stack_operation;
    logic        o_stack_function;
    logic        o_mem_read;
    logic        o_mem_write;
    logic        o_push_pc;
    logic        o_pop_pc;
    logic        o_branch_flags;
    logic        o_hazard_state;
    logic        o_call_jump;
    logic        o_pc_load;
    logic [31:0] o_pc_target;
    logic        o_stall;
    logic        o_busy;
    logic        o_stack_fault;

    modport master (
        input  i_call, i_ret, i_rti, i_int,
        output o_stack_operation, o_stack_function, o_mem_read, o_mem_write,
               o_push_pc, o_pop_pc, o_branch_flags, o_hazard_state, o_call_jump,
               o_pc_load, o_pc_target, o_stall, o_busy, o_stack_fault
    );

    modport slave (
        output i_call, i_ret, i_rti, i_int,
        input  o_stack_operation, o_stack_function, o_mem_read, o_mem_write,
               o_push_pc, o_pop_pc, o_branch_flags, o_hazard_state, o_call_jump,
               o_pc_load, o_pc_target, o_stall, o_busy, o_stack_fault
    );
endinterface

// File: rtl/stack_sequencer.sv
// Moore FSM sequencing CALL/INT/RET/RTI as two 16-bit stack accesses each.
// Optional STACK_GUARD_EN adds a word-depth counter with a sticky overflow/underflow fault.
module stack_sequencer #(
    parameter logic [31:0] INT_VECTOR = 32'h0000_0000,
    parameter int unsigned DEPTH_W    = 8,
    parameter int unsigned MAX_WORDS  = 255
) (
    input  logic              i_clk,
    input  logic              i_reset,
    stack_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        StIdle, StPushHi, StPushLo, StIntJump, StPopLo, StPopHi
    } state_e;

    typedef enum logic [1:0] {OpCall, OpInt, OpRet, OpRti} op_e;

    state_e state_q, state_d;
    op_e    op_q, op_d;
    op_e    req_op;
    logic   pend_q, pend_d;
    logic   req, req_push, reject, accept;

    always_comb begin
        req_op = OpCall;
        if (bus.i_int || pend_q) req_op = OpInt;
        else if (bus.i_rti)      req_op = OpRti;
        else if (bus.i_ret)      req_op = OpRet;
    end

    assign req      = bus.i_int | pend_q | bus.i_rti | bus.i_ret | bus.i_call;
    assign req_push = (req_op == OpCall) || (req_op == OpInt);

`ifdef STACK_GUARD_EN
    localparam logic [DEPTH_W:0] MaxWords = (DEPTH_W + 1)'(MAX_WORDS);
    localparam logic [DEPTH_W:0] SeqWords = (DEPTH_W + 1)'(2);

    logic [DEPTH_W-1:0] depth_q, depth_d;
    logic               fault_q, fault_d;

    assign reject = req && (req_push ? (({1'b0, depth_q} + SeqWords) > MaxWords)
                                     : (depth_q < DEPTH_W'(2)));

    always_comb begin
        depth_d = depth_q;
        if (state_q == StPushHi || state_q == StPushLo) depth_d = depth_q + 1'b1;
        else if (state_q == StPopLo || state_q == StPopHi) depth_d = depth_q - 1'b1;
        fault_d = fault_q | ((state_q == StIdle) && reject);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            depth_q <= '0;
            fault_q <= 1'b0;
        end else begin
            depth_q <= depth_d;
            fault_q <= fault_d;
        end
    end

    assign bus.o_stack_fault = fault_q;
`else
    assign reject            = 1'b0;
    assign bus.o_stack_fault = 1'b0;
`endif

    assign accept = (state_q == StIdle) && req && !reject && !i_reset;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        pend_d  = pend_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    op_d    = req_op;
                    pend_d  = 1'b0;
                    state_d = req_push ? StPushHi : StPopLo;
                end else if (reject) begin
                    // A refused interrupt is dropped rather than faulting every idle cycle
                    pend_d = 1'b0;
                end
            end
            StPushHi:  state_d = StPushLo;
            StPushLo:  state_d = (op_q == OpInt) ? StIntJump : StIdle;
            StIntJump: state_d = StIdle;
            StPopLo:   state_d = StPopHi;
            StPopHi:   state_d = StIdle;
            default:   state_d = StIdle;
        endcase
        if (state_q != StIdle && bus.i_int) pend_d = 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= StIdle;
            op_q    <= OpCall;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            pend_q  <= pend_d;
        end
    end

    always_comb begin
        bus.o_stack_operation = 1'b0;
        bus.o_stack_function  = 1'b0;
        bus.o_mem_read        = 1'b0;
        bus.o_mem_write       = 1'b0;
        bus.o_push_pc         = 1'b0;
        bus.o_pop_pc          = 1'b0;
        bus.o_branch_flags    = 1'b0;
        bus.o_hazard_state    = 1'b0;
        bus.o_call_jump       = 1'b0;
        bus.o_pc_load         = 1'b0;
        bus.o_pc_target       = 32'h0;
        unique case (state_q)
            StPushHi, StPushLo: begin
                bus.o_stack_operation = 1'b1;
                bus.o_stack_function  = 1'b1;
                bus.o_mem_write       = 1'b1;
                bus.o_push_pc         = 1'b1;
                bus.o_branch_flags    = (op_q == OpCall);
                bus.o_hazard_state    = (state_q == StPushLo);
                bus.o_call_jump       = (state_q == StPushLo) && (op_q == OpCall);
            end
            StIntJump: begin
                bus.o_pc_load   = 1'b1;
                bus.o_pc_target = INT_VECTOR;
            end
            StPopLo, StPopHi: begin
                bus.o_stack_operation = 1'b1;
                bus.o_mem_read        = 1'b1;
                bus.o_pop_pc          = 1'b1;
                bus.o_hazard_state    = (state_q == StPopHi);
                bus.o_branch_flags    = (state_q == StPopHi) && (op_q == OpRti);
            end
            default: ;
        endcase
        bus.o_busy  = (state_q != StIdle);
        bus.o_stall = (state_q != StIdle) | accept;
    end

endmodule

// File: doc/stack_sequencer.md
Name: stack_sequencer

Overview:
- Multi-cycle controller for the execute-memory stage's PC/flag stack path. Sequences CALL, INT, RET and RTI as two 16-bit stack accesses each.
- Drives the stage's stack, memory, push_pc/pop_pc, branch_flags and hazard_state controls.
- Stalls the front end while a sequence is active. Redirects the PC to the interrupt vector after an INT.
- Sits beside the execute-memory stage, fed by the decode/EX buffer.

Parameters:
- INT_VECTOR, 32'h0000_0000, PC loaded after an interrupt push completes.
- DEPTH_W, 8, width of the stack-depth counter (used only with the optional feature).
- MAX_WORDS, 255, stack capacity in 16-bit words (used only with the optional feature).

Ports:
- i_clk  in  1  clock, rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_call  in  1  CALL instruction valid in EX.
- i_ret  in  1  RET instruction valid in EX.
- i_rti  in  1  RTI instruction valid in EX.
- i_int  in  1  external interrupt request, level.
- o_stack_operation  out  1  stack pointer update enable.
- o_stack_function  out  1  1 = push, 0 = pop.
- o_mem_read  out  1  memory read enable.
- o_mem_write  out  1  memory write enable.
- o_push_pc  out  1  select PC word as write data.
- o_pop_pc  out  1  popped word feeds the PC.
- o_branch_flags  out  1  push: 1 = PC bits only, 0 = save flags in bits 31:29. Pop: 1 = restore flags.
- o_hazard_state  out  1  second-half indicator.
- o_call_jump  out  1  one-cycle pulse: take the CALL branch target.
- o_pc_load  out  1  one-cycle pulse: load o_pc_target.
- o_pc_target  out  32  INT_VECTOR while o_pc_load = 1, else 0.
- o_stall  out  1  freeze fetch/decode and the EX buffer.
- o_busy  out  1  state != IDLE.
- o_stack_fault  out  1  sticky stack guard fault.

Behaviour:
- Clock and reset: single clock domain, i_clk. Synchronous active-high reset on i_reset.
- Reset mid-sequence:
  - Returns to IDLE the next edge and clears the pending-interrupt latch.
  - All outputs go to 0 and o_pc_target = 0.
  - No partial pop reaches the PC.
- Moore FSM; all control outputs are decoded from the state register.
- States: IDLE, PUSH_HI, PUSH_LO, INT_JUMP, POP_LO, POP_HI.
- Request sampled in IDLE at edge N. Priority when simultaneous: int (or pending) > rti > ret > call.
- CALL/INT sequence: PUSH_HI in cycle N+1, PUSH_LO in N+2.
  - CALL: PUSH_LO -> IDLE, with o_call_jump = 1 in PUSH_LO.
  - INT: PUSH_LO -> INT_JUMP (N+3, o_pc_load = 1) -> IDLE.
- RET/RTI sequence: POP_LO in N+1, POP_HI in N+2, then IDLE.
- PUSH_HI outputs:
  - stack_operation = 1, stack_function = 1, mem_write = 1, push_pc = 1, hazard_state = 0.
  - branch_flags = 1 for CALL, 0 for INT (flags saved into PC[31:29]).
- PUSH_LO: same as PUSH_HI but hazard_state = 1. Pop order is therefore low word first.
- POP_LO: stack_operation = 1, stack_function = 0, mem_read = 1, pop_pc = 1, hazard_state = 0. The stage latches the low word.
- POP_HI: as POP_LO with hazard_state = 1. branch_flags = 1 for RTI (flags restored from mem[15:13]), 0 for RET. The PC loads in this cycle.
- o_stall = 1 in every non-IDLE state and in the IDLE cycle a request is accepted (combinational on request in IDLE only).
- Interrupt during a sequence: i_int is latched into a pending bit and serviced on the first IDLE cycle. It never preempts a sequence.
- A new request arriving in the final state is ignored until IDLE; the stalled pipeline re-presents it.
- Latency: CALL/RET/RTI = 2 busy cycles, INT = 3.

Optional Feature:
- Macro: STACK_GUARD_EN.
- With the macro:
  - DEPTH_W-bit counter of pushed words: +1 per push cycle, -1 per pop cycle. Reset to 0.
  - A request whose sequence would exceed MAX_WORDS or pop below 0 is rejected: the FSM stays IDLE, o_stack_fault is set, and o_stall is not raised.
  - o_stack_fault clears only on reset.
- Without the macro: no counter; o_stack_fault tied 0; all requests accepted.

Test Plan:
- Reset, then idle 3 cycles -> all outputs 0; o_pc_target = 0; o_busy = 0.
- i_call pulse at cycle 5:
  - cycle 6 PUSH_HI (mem_write = 1, hazard = 0, branch_flags = 1).
  - cycle 7 PUSH_LO (hazard = 1, o_call_jump = 1).
  - cycle 8 IDLE; o_stall high in cycles 5-7.
- i_int with i_call simultaneously -> INT wins:
  - PUSH_HI/PUSH_LO with branch_flags = 0, then INT_JUMP with o_pc_load = 1 and o_pc_target = INT_VECTOR.
  - CALL is serviced once re-presented.
- i_rti -> POP_LO (pop_pc = 1, hazard = 0), then POP_HI (hazard = 1, branch_flags = 1). i_ret gives the same sequence with branch_flags = 0 in POP_HI.
- i_int asserted during POP_LO of a RET -> RET completes, then PUSH_HI starts the cycle after IDLE. Reset asserted in PUSH_LO -> IDLE next cycle, pending cleared.
- With STACK_GUARD_EN: i_ret at depth 0 -> no state change, o_stack_fault = 1 and stays 1. CALL with MAX_WORDS = 2: first CALL accepted (depth 2); a second CALL is rejected with a fault.
